// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a SPRITE_W x SPRITE_H bitmap one pixel per clock and issues VGA plot writes.
// Define SPRITE_BLITTER_MIRROR_EN to add a 'mirror' input that flips the bitmap horizontally.
module sprite_blitter #(
  parameter int SPRITE_W = 5,
  parameter int SPRITE_H = 5,
  parameter int COLOUR_W = 3,
  parameter int X_W      = 8,
  parameter int Y_W      = 7
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         go,
  input  logic [X_W-1:0]               x_in,
  input  logic [Y_W-1:0]               y_in,
  input  logic [SPRITE_W*SPRITE_H-1:0] shape,
  input  logic [COLOUR_W-1:0]          colour,
  input  logic [COLOUR_W-1:0]          bg_colour,
  input  logic                         transparent,
`ifdef SPRITE_BLITTER_MIRROR_EN
  input  logic                         mirror,
`endif
  output logic                         plot,
  output logic [X_W-1:0]               x_out,
  output logic [Y_W-1:0]               y_out,
  output logic [COLOUR_W-1:0]          col_out,
  output logic                         busy,
  output logic                         done
);

  localparam int N_PIX = SPRITE_W * SPRITE_H;
  localparam int CW    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int IW    = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(SPRITE_H - 1);
  localparam logic [IW-1:0]  PIX_LAST = IW'(N_PIX - 1);
  localparam logic [IW-1:0]  SW_I     = IW'(SPRITE_W);
  localparam logic [X_W-1:0] SW_X     = X_W'(SPRITE_W);
  localparam logic [Y_W-1:0] SH_Y     = Y_W'(SPRITE_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [CW-1:0]         col_r, col_nxt_s;
  logic [RW-1:0]         row_r, row_nxt_s;
  logic [X_W-1:0]        org_x_r, org_x_nxt_s;
  logic [Y_W-1:0]        org_y_r, org_y_nxt_s;
  logic [N_PIX-1:0]      shape_r, shape_nxt_s;
  logic [COLOUR_W-1:0]   fg_r, fg_nxt_s;
  logic [COLOUR_W-1:0]   bg_r, bg_nxt_s;
  logic                  trans_r, trans_nxt_s;
  logic                  mirror_r, mirror_nxt_s;
  logic                  mirror_in_s;
  logic                  pix_bit_s;

`ifdef SPRITE_BLITTER_MIRROR_EN
  assign mirror_in_s = mirror;
`else
  assign mirror_in_s = 1'b0;
`endif

  // Bitmap bit for a given column/row; mirroring flips only which bit is read, not where it lands.
  function automatic logic pixel_bit(input logic [N_PIX-1:0] bits, input logic [CW-1:0] col,
                                     input logic [RW-1:0] row, input logic mir);
    logic [CW-1:0] src_col;
    logic [IW-1:0] idx;
    src_col = mir ? (COL_LAST - col) : col;
    idx     = PIX_LAST - ((IW'(row) * SW_I) + IW'(src_col));
    return bits[idx];
  endfunction

  // Next-state, pixel walk and sprite capture
  always_comb begin
    state_nxt_s  = state_r;
    col_nxt_s    = col_r;
    row_nxt_s    = row_r;
    org_x_nxt_s  = org_x_r;
    org_y_nxt_s  = org_y_r;
    shape_nxt_s  = shape_r;
    fg_nxt_s     = fg_r;
    bg_nxt_s     = bg_r;
    trans_nxt_s  = trans_r;
    mirror_nxt_s = mirror_r;
    case (state_r)
      IDLE: begin
        if (go) begin
          state_nxt_s  = DRAW;
          col_nxt_s    = '0;
          row_nxt_s    = '0;
          org_x_nxt_s  = x_in * SW_X;
          org_y_nxt_s  = y_in * SH_Y;
          shape_nxt_s  = shape;
          fg_nxt_s     = colour;
          bg_nxt_s     = bg_colour;
          trans_nxt_s  = transparent;
          mirror_nxt_s = mirror_in_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAW: begin
        if (col_r == COL_LAST) begin
          col_nxt_s = '0;
          if (row_r == ROW_LAST) begin
            row_nxt_s   = '0;
            state_nxt_s = DONE;
          end else begin
            row_nxt_s = row_r + RW'(1);
          end
        end else begin
          col_nxt_s = col_r + CW'(1);
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  assign pix_bit_s = pixel_bit(shape_nxt_s, col_nxt_s, row_nxt_s, mirror_nxt_s);

  // FSM, counters and latched sprite attributes
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      col_r    <= '0;
      row_r    <= '0;
      org_x_r  <= '0;
      org_y_r  <= '0;
      shape_r  <= '0;
      fg_r     <= '0;
      bg_r     <= '0;
      trans_r  <= 1'b0;
      mirror_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      col_r    <= col_nxt_s;
      row_r    <= row_nxt_s;
      org_x_r  <= org_x_nxt_s;
      org_y_r  <= org_y_nxt_s;
      shape_r  <= shape_nxt_s;
      fg_r     <= fg_nxt_s;
      bg_r     <= bg_nxt_s;
      trans_r  <= trans_nxt_s;
      mirror_r <= mirror_nxt_s;
    end
  end

  // Outputs registered from the pixel being entered, so pixel 0 appears the cycle after go
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      plot    <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      col_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      plot    <= (state_nxt_s == DRAW) && (pix_bit_s || !trans_nxt_s);
      x_out   <= org_x_nxt_s + X_W'(col_nxt_s);
      y_out   <= org_y_nxt_s + Y_W'(row_nxt_s);
      col_out <= pix_bit_s ? fg_nxt_s : bg_nxt_s;
      busy    <= (state_nxt_s != IDLE);
      done    <= (state_nxt_s == DONE);
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a reference model queues every expected plot/done event
// with its cycle stamp; a monitor pops and compares whenever the DUT plots or signals done.
module tb_sprite_blitter;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int CB = 3;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int NP = W * H;
  localparam logic [NP-1:0] PACMAN = 25'h0EFE3EE;
`ifdef SPRITE_BLITTER_MIRROR_EN
  localparam bit HAS_MIRROR = 1'b1;
`else
  localparam bit HAS_MIRROR = 1'b0;
`endif

  typedef struct {
    int stamp;
    bit is_done;
    int x;
    int y;
    int col;
  } sb_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          go = 1'b0;
  logic [XW-1:0] x_in = '0;
  logic [YW-1:0] y_in = '0;
  logic [NP-1:0] shape = '0;
  logic [CB-1:0] colour = '0;
  logic [CB-1:0] bg_colour = '0;
  logic          transparent = 1'b0;
`ifdef SPRITE_BLITTER_MIRROR_EN
  logic          mirror = 1'b0;
`endif
  logic          plot;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [CB-1:0] col_out;
  logic          busy;
  logic          done;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  plot_cnt = 0;
  sb_t sb[$];
  sb_t mon_e;

  sprite_blitter #(.SPRITE_W(W), .SPRITE_H(H), .COLOUR_W(CB), .X_W(XW), .Y_W(YW)) dut (
    .clock(clock), .reset_n(reset_n), .go(go), .x_in(x_in), .y_in(y_in), .shape(shape),
    .colour(colour), .bg_colour(bg_colour), .transparent(transparent),
`ifdef SPRITE_BLITTER_MIRROR_EN
    .mirror(mirror),
`endif
    .plot(plot), .x_out(x_out), .y_out(y_out), .col_out(col_out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: pixel k of the sprite appears k cycles after the accepting edge, done NP cycles after it
  task automatic model(input int n0, input int xi, input int yi, input logic [NP-1:0] shp,
                       input int fg, input int bgc, input bit tr, input bit mir);
    sb_t e;
    int  src;
    bit  b;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        src = mir ? (W - 1 - c) : c;
        b   = shp[NP - 1 - (r * W + src)];
        if (b || !tr) begin
          e.stamp = n0 + r * W + c;
          e.is_done = 1'b0;
          e.x = (xi * W + c) % (1 << XW);
          e.y = (yi * H + r) % (1 << YW);
          e.col = b ? fg : bgc;
          sb.push_back(e);
        end
      end
    end
    e.stamp = n0 + NP;
    e.is_done = 1'b1;
    e.x = 0;
    e.y = 0;
    e.col = 0;
    sb.push_back(e);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the accepting edge (or later with poke)
  task automatic issue(input int xi, input int yi, input logic [NP-1:0] shp, input int fg,
                       input int bgc, input bit tr, input bit mir, input bit poke);
    int n0;
    x_in = XW'(xi);
    y_in = YW'(yi);
    shape = shp;
    colour = CB'(fg);
    bg_colour = CB'(bgc);
    transparent = tr;
`ifdef SPRITE_BLITTER_MIRROR_EN
    mirror = mir;
`endif
    go = 1'b1;
    n0 = cyc + 1;
    model(n0, xi, yi, shp, fg, bgc, tr, HAS_MIRROR && mir);
    @(posedge clock);
    #1;
    go = 1'b0;
    x_in = XW'($urandom);
    y_in = YW'($urandom);
    shape = NP'($urandom);
    colour = CB'($urandom);
    bg_colour = CB'($urandom);
    transparent = ~tr;
`ifdef SPRITE_BLITTER_MIRROR_EN
    mirror = ~mir;
`endif
    if (poke) begin
      @(posedge clock);
      #1 go = 1'b1;
      repeat (3) @(posedge clock);
      #1 go = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clock);
    #1;
    check("drain_empty", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    check("idle_busy", busy, 0);
  endtask

  // Monitor: every plot or done must match the head of the scoreboard
  always @(negedge clock) begin
    if (plot || done) begin
      if (plot) plot_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: plot=%0b done=%0b x=%0d y=%0d cycle %0d", plot, done, x_out, y_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("stamp", cyc, mon_e.stamp);
        check("done", done, mon_e.is_done);
        check("busy", busy, 1);
        if (!mon_e.is_done) begin
          check("x_out", x_out, mon_e.x);
          check("y_out", y_out, mon_e.y);
          check("col_out", col_out, mon_e.col);
        end
      end
    end
  end

  initial begin
    go = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_col", col_out, 0);
    go = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    plot_cnt = 0;
    issue(2, 3, PACMAN, 6, 1, 1'b0, 1'b0, 1'b1);
    drain();
    check("opaque_plots", plot_cnt, 25);

    plot_cnt = 0;
    issue(2, 3, PACMAN, 6, 1, 1'b1, 1'b0, 1'b0);
    drain();
    check("transparent_plots", plot_cnt, 18);

    issue(51, 25, PACMAN, 3, 4, 1'b0, 1'b0, 1'b1);
    drain();

    // Abort mid-draw at pixel 12
    plot_cnt = 0;
    issue(2, 3, PACMAN, 6, 1, 1'b0, 1'b0, 1'b0);
    repeat (12) @(posedge clock);
    #1 reset_n = 1'b0;
    go = 1'b1;
    @(posedge clock);
    #1;
    sb.delete();
    check("abort_plots", plot_cnt, 13);
    check("abort_plot", plot, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    go = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("post_abort_busy", busy, 0);
    plot_cnt = 0;
    issue(2, 3, PACMAN, 6, 1, 1'b0, 1'b0, 1'b0);
    drain();
    check("redraw_plots", plot_cnt, 25);

    // go held high: sprites every NP+2 cycles
    begin
      int n0;
      x_in = XW'(7);
      y_in = YW'(9);
      shape = PACMAN;
      colour = CB'(5);
      bg_colour = CB'(2);
      transparent = 1'b1;
`ifdef SPRITE_BLITTER_MIRROR_EN
      mirror = 1'b0;
`endif
      go = 1'b1;
      n0 = cyc + 1;
      for (int k = 0; k < 3; k++) model(n0 + k * (NP + 2), 7, 9, PACMAN, 5, 2, 1'b1, 1'b0);
      drain();
      go = 1'b0;
    end

`ifdef SPRITE_BLITTER_MIRROR_EN
    plot_cnt = 0;
    issue(4, 2, 25'h1000000, 7, 0, 1'b1, 1'b1, 1'b0);
    drain();
    check("mirror_plots", plot_cnt, 1);
`endif

    for (int k = 0; k < 10; k++) begin
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), NP'($urandom),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain();
    end

    repeat (5) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter SPRITE_W, default 5, meaning sprite width in pixels (1..16).
REQ-002 SHALL have parameter SPRITE_H, default 5, meaning sprite height in pixels (1..16).
REQ-003 SHALL have parameter COLOUR_W, default 3, meaning colour bits per pixel.
REQ-004 SHALL have parameter X_W, default 8, meaning screen x coordinate width.
REQ-005 SHALL have parameter Y_W, default 7, meaning screen y coordinate width.
REQ-006 SHALL have port clock, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, meaning synchronous active-low reset.
REQ-008 SHALL have port go, input, 1, meaning start request, sampled only in IDLE.
REQ-009 SHALL have port x_in, input, X_W, meaning tile column; pixel origin = x_in*SPRITE_W.
REQ-010 SHALL have port y_in, input, Y_W, meaning tile row; pixel origin = y_in*SPRITE_H.
REQ-011 SHALL have port shape, input, SPRITE_W*SPRITE_H, meaning bitmap, MSB = top-left, row-major.
REQ-012 SHALL have port colour, input, COLOUR_W, meaning foreground colour for 1-bits.
REQ-013 SHALL have port bg_colour, input, COLOUR_W, meaning background colour for 0-bits.
REQ-014 SHALL have port transparent, input, 1, meaning 0-bits are skipped (no plot) when 1.
REQ-015 SHALL have port plot, output, 1, meaning write-enable to the VGA adapter.
REQ-016 SHALL have ports x_out (X_W), y_out (Y_W), col_out (COLOUR_W), outputs, meaning pixel address and colour.
REQ-017 SHALL have ports busy and done, outputs, 1 each, meaning draw in progress / one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, DRAW, DONE; IDLE->DRAW on go=1; DRAW->DONE after last pixel; DONE->IDLE unconditionally.
REQ-019 SHALL, on the IDLE->DRAW edge, latch origin (x_in*SPRITE_W, y_in*SPRITE_H truncated to X_W/Y_W), shape, colour, bg_colour, transparent, and clear column/row counters.
REQ-020 SHALL ignore all inputs except reset_n while busy; changes mid-draw have no effect on the current sprite.
REQ-021 SHALL, in DRAW, visit one pixel per cycle in row-major order: column 0..SPRITE_W-1, then row increments, total SPRITE_W*SPRITE_H cycles.
REQ-022 SHALL drive x_out = origin_x + column and y_out = origin_y + row, modulo 2^X_W and 2^Y_W (wrap, no saturation).
REQ-023 SHALL select bit shape[SPRITE_W*SPRITE_H-1-(row*SPRITE_W+column)] for each pixel; col_out = colour if 1, bg_colour if 0.
REQ-024 SHALL assert plot in DRAW for every pixel, except 0-bits when latched transparent=1.
REQ-025 SHALL hold plot=0 in IDLE and DONE; x_out/y_out/col_out are don't-care when plot=0.
REQ-026 SHALL assert busy in DRAW and DONE; done=1 for exactly the single DONE cycle.
REQ-027 SHALL give latency: go sampled at edge N, first pixel valid cycle N+1, done high cycle N+1+SPRITE_W*SPRITE_H.
REQ-028 SHALL accept a new go in the cycle after DONE (back-to-back sprites, one idle cycle between).
REQ-029 SHALL handle SPRITE_W=1 and/or SPRITE_H=1 correctly (single-pixel rows/columns).

Reset
REQ-030 SHALL, when reset_n=0 at a rising edge, force IDLE, counters 0, latched registers 0, plot=0, busy=0, done=0, x_out=0, y_out=0, col_out=0.
REQ-031 SHALL abort a draw in progress on reset with no further plot and no done pulse.
REQ-032 SHALL give reset priority over go in the same cycle.

Configuration
REQ-033 SHALL, when macro SPRITE_BLITTER_MIRROR_EN is defined, add input mirror (1 bit, latched with go) that, when 1, selects bit column SPRITE_W-1-column while x_out still advances left to right.
REQ-034 SHALL, without SPRITE_BLITTER_MIRROR_EN, have no mirror port and always draw unmirrored.

Verification
REQ-035 SHALL test defaults, x_in=2, y_in=3, shape=25'h0EFE3EE (pacman), colour=3'b110, transparent=0 -> 25 plot cycles, first (10,15), last (14,19), done at cycle 26.
REQ-036 SHALL test transparent=1, same shape -> plot only on 1-bits (18 pulses), none for 0-bits, total cycle count unchanged.
REQ-037 SHALL test x_in=51 (origin 255) -> x_out wraps 255,0,1,2,3 per row.
REQ-038 SHALL test reset_n=0 at pixel 12 -> plot drops next cycle, no done, busy=0; next go redraws from pixel 0.
REQ-039 SHALL test go held high continuously -> sprites repeat with exactly one IDLE cycle between done and next first pixel.
REQ-040 SHALL test with SPRITE_BLITTER_MIRROR_EN, mirror=1, shape row 0 = 10000 -> foreground pixel at column 4 of row 0.
